// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: request handshake plus response strobe.
// slave is the arbiter's view, master is the client side.
interface rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM among NREQ requesters.
// One acceptance per cycle; the response is a one-cycle strobe two edges later.
module rom_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 4,
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_arbiter_if.slave  bus,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] grant;
  logic            s1_vld, s2_vld;
  logic [IW-1:0]   s1_id, s2_id;

  // Index reached k steps after base, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] scan_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin pick: first valid requester starting at ptr.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[scan_idx(ptr, k)]) begin
        found = 1'b1;
        win   = scan_idx(ptr, k);
      end
    end
    grant = found ? (NREQ'(1) << win) : '0;
  end

  // Acceptance updates the pointer and ROM address; the id/valid pipeline tracks ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, matching hardware.
    if (!rst_n) begin
      ptr      <= '0;
      rom_addr <= '0;
      s1_vld   <= 1'b0;
      s1_id    <= '0;
      s2_vld   <= 1'b0;
      s2_id    <= '0;
    end else begin
      s1_vld <= found;
      s2_vld <= s1_vld;
      s2_id  <= s1_id;
      if (found) begin
        rom_addr <= bus.req_addr[win*AW +: AW];
        s1_id    <= win;
        ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
      end
    end
  end

  // Grant and response are decoded combinationally; async reset clears them at once via the registers.
  always_comb begin
    bus.req_ready = grant;
    bus.rsp_valid = s2_vld ? (NREQ'(1) << s2_id) : '0;
    bus.rsp_data  = rom_data;
    bus.busy      = s1_vld | s2_vld;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a registered-output ROM model and an in-order response scoreboard.
module tb_rom_arbiter;
  localparam int AW = 5, DW = 4, NREQ = 4, IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rom [32];
  logic [AW-1:0] addr_a [NREQ];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rom_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: one-cycle registered read; contents are addr XOR 4'hF.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive valid bits at a falling edge, check the grant, log the expected response, advance a cycle.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] exp_ready,
                      input bit push, input string nm);
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = addr_a[i];
    bus.req_valid = v;
    #1;
    check({nm, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
    if (push && exp_ready != '0) begin
      for (int i = 0; i < NREQ; i++)
        if (exp_ready[i]) exp_q.push_back('{id: IW'(i), data: rom[addr_a[i]], due: cyc + 2});
    end
    @(negedge clk);
  endtask

  // Monitor: compare every presented response with the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("rsp_missing_due", 32'(exp_q[0].due), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_valid", 32'(bus.rsp_valid), 32'(NREQ'(1) << e.id));
          check("rsp_data",  32'(bus.rsp_data),  32'(e.data));
          check("rsp_cycle", 32'(cyc),           32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 4'(i) ^ 4'hF;
    for (int i = 0; i < NREQ; i++) addr_a[i] = '0;
    bus.req_valid = '0;
    bus.req_addr  = '0;

    // Reset values with arbitrary requests present.
    repeat (3) begin
      @(negedge clk);
      bus.req_valid = NREQ'($urandom);
      #1;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      check("rst_busy",      32'(bus.busy),      32'(0));
      check("rst_rom_addr",  32'(rom_addr),      32'(0));
    end
    bus.req_valid = 4'b0110;
    #1;
    check("rst_ready_ptr0", 32'(bus.req_ready), 32'(4'b0010));
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, rom[5] = 4'hA, two-edge latency, busy drains.
    addr_a[2] = 5'd5;
    check("rom5_model", 32'(rom[5]), 32'(4'hA));
    step(4'b0100, 4'b0100, 1'b1, "single");
    check("single_busy_s1", 32'(bus.busy), 32'(1));
    step(4'b0000, 4'b0000, 1'b1, "idle_a");
    check("single_busy_s2", 32'(bus.busy), 32'(1));
    step(4'b0000, 4'b0000, 1'b1, "idle_b");
    check("single_busy_done", 32'(bus.busy), 32'(0));

    // Pointer rotation and wrap: ptr is 3 after granting 2.
    addr_a[3] = 5'd9;
    addr_a[0] = 5'd6;
    step(4'b1000, 4'b1000, 1'b1, "wrap_g3");
    step(4'b1001, 4'b0001, 1'b1, "wrap_g0");
    step(4'b1000, 4'b1000, 1'b1, "wrap_g3b");

    // Full contention from ptr=0: strict rotation, one grant per cycle.
    for (int i = 0; i < NREQ; i++) addr_a[i] = AW'(i + 1);
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 4'b0001, 1'b1, "all_g0");
      step(4'b1111, 4'b0010, 1'b1, "all_g1");
      step(4'b1111, 4'b0100, 1'b1, "all_g2");
      step(4'b1111, 4'b1000, 1'b1, "all_g3");
    end

    // Back-to-back single requester, addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      addr_a[1] = AW'(i);
      step(4'b0010, 4'b0010, 1'b1, "b2b_g1");
    end
    repeat (3) step(4'b0000, 4'b0000, 1'b1, "drain");
    check("b2b_busy_done", 32'(bus.busy), 32'(0));

    // Reset mid-flight: ptr is 2 here; accept 0 then 2, then reset between edges.
    addr_a[0] = 5'd3;
    addr_a[2] = 5'd11;
    step(4'b0001, 4'b0001, 1'b0, "mid_g0");
    bus.req_addr[2*AW +: AW] = addr_a[2];
    bus.req_valid = 4'b0100;
    #1;
    check("mid_g2_ready", 32'(bus.req_ready), 32'(4'b0100));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("mid_rst_busy",      32'(bus.busy),      32'(0));
    check("mid_rst_rom_addr",  32'(rom_addr),      32'(0));
    check("mid_rst_ready",     32'(bus.req_ready), 32'(4'b0010));
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(4'b0000, 4'b0000, 1'b1, "post_rst_idle");
    step(4'b1111, 4'b0001, 1'b1, "post_rst_g0");
    repeat (3) step(4'b0000, 4'b0000, 1'b1, "final_drain");
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one synchronous ROM (`genrom`, registered output, one-cycle read latency) among NREQ requesters. Accepts at most one read request per cycle via valid/ready handshakes, drives the ROM address, and returns the read data to the winning requester as a one-cycle response pulse. Sits between the ROM and its client blocks (for example, UART transmit sequencers and lookup consumers), so they never drive the ROM address directly.

## Interface
- AW, 5, ROM address width; must match the ROM instance.
- DW, 4, ROM data width; must match the ROM instance.
- NREQ, 4, number of requesters; legal range 2..8.
- IW, 2, requester-index width; must satisfy 2**IW >= NREQ.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester read request.
- req_addr  in  NREQ*AW  flat request addresses; requester i occupies bits [i*AW +: AW].
- req_ready  out  NREQ  one-hot grant; combinational from req_valid and the priority pointer.
- rom_addr  out  AW  registered address driven into the ROM `addr` input.
- rom_data  in  DW  ROM `data` output.
- rsp_valid  out  NREQ  one-hot response strobe, one cycle per accepted request.
- rsp_data  out  DW  read data; meaningful only while any rsp_valid bit is 1.
- busy  out  1  1 while any accepted request has not yet produced its response.

## Operation
- Handshake: requester i's request is accepted at a rising edge where req_valid[i] and req_ready[i] are both 1. A requester holds req_valid and its address stable until it is accepted. Dropping req_valid before acceptance is illegal.
- Arbitration: `ptr` (IW bits) is the highest-priority index. The winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. If there is no valid request, req_ready is all 0.
- On acceptance of winner w:
  - rom_addr <= req_addr[w]
  - s1_id <= w, s1_vld <= 1
  - ptr <= (w == NREQ-1) ? 0 : w+1
- Without acceptance: ptr and rom_addr hold their values; s1_vld <= 0.
- Pipeline: s2_vld <= s1_vld and s2_id <= s1_id every cycle. rsp_valid = s2_vld ? (1 << s2_id) : 0. rsp_data = rom_data (combinational pass-through).
- There is no response backpressure. Requesters must take the response in the cycle it is presented.
- busy = s1_vld | s2_vld.
- Reset (asynchronous, any time):
  - ptr=0, rom_addr=0, s1_vld=s2_vld=0, s1_id=s2_id=0.
  - Consequently rsp_valid=0, busy=0, and req_ready is purely combinational on req_valid with ptr=0.
  - In-flight requests are discarded with no response.
  - Outputs take their reset values immediately on rst_n falling, without waiting for a clock edge.
- Reset release: the first acceptance can occur at the first rising edge with rst_n=1.

## Timing
- Request accepted at edge E0.
- rom_addr is valid after E0, and the ROM samples it at E1.
- rom_data is valid after E1, and the arbiter captures s2_vld at E1.
- rsp_valid and rsp_data are valid in the cycle between E1 and E2. Latency is 2 edges from acceptance to response.
- Throughput: one acceptance per cycle, sustained indefinitely. Responses return in acceptance order, one per cycle, with no gaps beyond the gaps in acceptances.
- req_ready is combinational from req_valid and ptr, with no dependence on responses. A single requester that asserts valid continuously is granted every cycle.
- Pointer wrap: a grant to NREQ-1 sets ptr=0.
- Simultaneous requests from all NREQ requesters are served strictly in rotating order.

## Test plan
- Reset values: hold rst_n=0 with random req_valid -> rsp_valid=0, busy=0, rom_addr=0. With req_valid=4'b0110, req_ready=4'b0010 (ptr=0).
- Single request, latency: with ROM holding rom[5]=4'hA, requester 2 asserts valid with addr 5 for one accepted cycle -> rsp_valid=4'b0100 and rsp_data=4'hA exactly 2 edges after acceptance, then busy returns to 0.
- Full contention: all 4 requesters are held valid with addrs 1, 2, 3, 4 and re-request after each grant -> grants follow 0, 1, 2, 3, 0, 1… one per cycle, and the responses return rom[1], rom[2], rom[3], rom[4] tagged to the matching ids.
- Pointer rotation and wrap: grant requester 3, then assert requesters 0 and 3 together -> requester 0 is granted first (ptr=0 after wrap), then requester 3.
- Back-to-back single requester: requester 1 holds valid for 8 cycles with addresses 0..7 -> 8 acceptances and 8 consecutive responses rom[0..7]. req_ready[1] stays 1 throughout.
- Reset mid-flight: accept requests at two consecutive edges, then drop rst_n asynchronously between edges -> rsp_valid and busy go to 0 immediately, no response appears after release, and the next grant starts from ptr=0.
